mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-to-one arbiter that merges the pipeline's instruction-fetch channel (read-only) and data-memory channel (read/write) onto one unified memory port.
- Sits between the five-stage core's IF/MA stages and the shared memory/cache bus.
- Sequences one transaction at a time and routes each read response back to its requester.
- Favours data (MA stall) requests, with an anti-starvation guard for fetch.

Parameters:
STARVE_MAX, 8, consecutive cycles a pending fetch may lose arbitration before it is forced to win (1..255)
CNT_W, 32, width of the grant/contention statistic counters

Ports:
clk  in  1  clock
rst  in  1  reset
inst_addr  in  32  fetch address
inst_req_valid  in  1  fetch request; held stable until inst_req_ready
inst_req_ready  out  1  fetch request accepted
inst_rdata  out  32  fetch read data
inst_rvalid  out  1  fetch response valid
inst_rready  in  1  fetch side accepts response
data_addr  in  32  load/store address
data_ren  in  1  load request; held until data_req_ready
data_wen  in  1  store request; held until data_req_ready
data_wdata  in  32  store data
data_wstrb  in  4  store byte strobes
data_req_ready  out  1  data request accepted
data_rdata  out  32  load read data
data_rvalid  out  1  load response valid
data_rready  in  1  data side accepts response
mem_addr  out  32  unified address
mem_read  out  1  unified read request
mem_write  out  1  unified write request
mem_wdata  out  32  unified write data
mem_wstrb  out  4  unified strobes
mem_req_ready  in  1  memory accepts request
mem_rdata  in  32  memory read data
mem_rvalid  in  1  memory response valid
mem_rready  out  1  arbiter accepts response
inst_grant_cnt  out  CNT_W  accepted fetch requests
data_grant_cnt  out  CNT_W  accepted data requests
contend_cnt  out  CNT_W  cycles in IDLE with both requesters pending

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock.
  - On reset: state=IDLE, wait counter=0, all statistic counters=0.
  - Every ready/valid/read/write output is 0 while in IDLE.
  - Reset mid-transaction abandons it at once. A late mem_rvalid is never accepted, because mem_rready=0 outside the RESP states.
- States: IDLE, I_REQ, D_REQ, I_RESP, D_RESP.
- IDLE arbitration. data_pend=data_ren|data_wen.
  - Both pending: go to D_REQ unless wait_cnt==STARVE_MAX, in which case go to I_REQ.
  - Only one pending: that one wins.
  - Neither pending: stay in IDLE.
  - The decision is registered, so there is 1 cycle of arbitration latency.
- I_REQ:
  - mem_addr=inst_addr, mem_read=1, mem_write=0.
  - inst_req_ready=mem_req_ready.
  - On mem_req_ready: go to I_RESP, inst_grant_cnt++, wait_cnt:=0.
- D_REQ:
  - mem_addr/wdata/wstrb come from the data side; mem_write=data_wen; mem_read=data_ren&~data_wen (wen wins if both set).
  - data_req_ready=mem_req_ready.
  - On acceptance data_grant_cnt++. A write goes to IDLE (no response phase); a read goes to D_RESP.
- x_RESP:
  - mem_rready=x_rready; x_rvalid=mem_rvalid; x_rdata=mem_rdata. The other side's rvalid=0.
  - On mem_rvalid&x_rready: go to IDLE.
- Outputs in non-owning states: mem_* request outputs are 0 outside the REQ states. Data/address outputs are 0 when not driven.
- Throughput: minimum 3 cycles per read and 2 per write, since IDLE is always revisited.
- wait_cnt:
  - +1 each cycle inst_req_valid=1 and state is not I_REQ/I_RESP.
  - Saturates at STARVE_MAX; clears on fetch acceptance.
- contend_cnt: +1 each IDLE cycle with inst_req_valid & data_pend.
- Statistic counters wrap modulo 2^CNT_W.
- Accept and response never coincide in the same cycle, because the response phase starts the cycle after acceptance.

Test Plan:
- Single fetch: inst_req_valid=1 with addr 0x100, memory ready immediately, rdata 0x00000013 after 2 cycles → mem_read high 1 cycle after the request; inst_rvalid with 0x00000013; inst_grant_cnt=1; data outputs stay 0.
- Store: data_wen=1, addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF, mem_req_ready delayed 3 cycles → mem_write held 4 cycles with stable fields; data_req_ready pulses once; no RESP state; returns to IDLE.
- Contention: both pending continuously with STARVE_MAX=8 and back-to-back loads → data wins; fetch is granted once wait_cnt reaches 8; contend_cnt equals the number of IDLE cycles with both pending.
- Response backpressure: load response mem_rvalid=1 while data_rready=0 for 5 cycles → mem_rready=0 and state held in D_RESP; transfer completes on the cycle data_rready=1.
- Reset mid-read: rst asserted in I_RESP before mem_rvalid → next cycle IDLE, all counters 0, mem_rready=0, and the stale response is not forwarded.
- Illegal data_ren=data_wen=1 → treated as a write: mem_write=1, mem_read=0, no response phase.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : fetch/data 2:1 arbiter onto one unified memory port
// Revision 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_addr,
  input  logic             inst_req_valid,
  output logic             inst_req_ready,
  output logic [31:0]      inst_rdata,
  output logic             inst_rvalid,
  input  logic             inst_rready,
  input  logic [31:0]      data_addr,
  input  logic             data_ren,
  input  logic             data_wen,
  input  logic [31:0]      data_wdata,
  input  logic [3:0]       data_wstrb,
  output logic             data_req_ready,
  output logic [31:0]      data_rdata,
  output logic             data_rvalid,
  input  logic             data_rready,
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_req_ready,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic             mem_rready,
  output logic [CNT_W-1:0] inst_grant_cnt,
  output logic [CNT_W-1:0] data_grant_cnt,
  output logic [CNT_W-1:0] contend_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_I_REQ  = 3'd1,
    S_D_REQ  = 3'd2,
    S_I_RESP = 3'd3,
    S_D_RESP = 3'd4
  } state_t;

  localparam logic [7:0]       c_starve_max = 8'(STARVE_MAX);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] inst_grant_q, inst_grant_d;
  logic [CNT_W-1:0] data_grant_q, data_grant_d;
  logic [CNT_W-1:0] contend_q, contend_d;
  logic             data_pend;

  assign data_pend      = data_ren | data_wen;
  assign inst_grant_cnt = inst_grant_q;
  assign data_grant_cnt = data_grant_q;
  assign contend_cnt    = contend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_q       <= 8'd0;
      inst_grant_q <= '0;
      data_grant_q <= '0;
      contend_q    <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      inst_grant_q <= inst_grant_d;
      data_grant_q <= data_grant_d;
      contend_q    <= contend_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    inst_grant_d   = inst_grant_q;
    data_grant_d   = data_grant_q;
    contend_d      = contend_q;
    inst_req_ready = 1'b0;
    inst_rdata     = 32'd0;
    inst_rvalid    = 1'b0;
    data_req_ready = 1'b0;
    data_rdata     = 32'd0;
    data_rvalid    = 1'b0;
    mem_addr       = 32'd0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_wdata      = 32'd0;
    mem_wstrb      = 4'd0;
    mem_rready     = 1'b0;

    // Fetch ageing: counts every cycle a fetch waits outside its own transaction.
    if (inst_req_valid && state_q != S_I_REQ && state_q != S_I_RESP &&
        wait_q < c_starve_max) begin
      wait_d = wait_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (inst_req_valid && data_pend) begin
          contend_d = contend_q + c_cnt_one;
          state_d   = (wait_q == c_starve_max) ? S_I_REQ : S_D_REQ;
        end else if (inst_req_valid) begin
          state_d = S_I_REQ;
        end else if (data_pend) begin
          state_d = S_D_REQ;
        end
      end
      S_I_REQ: begin
        mem_addr       = inst_addr;
        mem_read       = 1'b1;
        inst_req_ready = mem_req_ready;
        if (mem_req_ready) begin
          inst_grant_d = inst_grant_q + c_cnt_one;
          wait_d       = 8'd0;
          state_d      = S_I_RESP;
        end
      end
      S_D_REQ: begin
        mem_addr       = data_addr;
        mem_wdata      = data_wdata;
        mem_wstrb      = data_wstrb;
        mem_write      = data_wen;
        mem_read       = data_ren & ~data_wen;
        data_req_ready = mem_req_ready;
        if (mem_req_ready) begin
          data_grant_d = data_grant_q + c_cnt_one;
          state_d      = data_wen ? S_IDLE : S_D_RESP;
        end
      end
      S_I_RESP: begin
        mem_rready  = inst_rready;
        inst_rvalid = mem_rvalid;
        inst_rdata  = mem_rdata;
        if (mem_rvalid && inst_rready) state_d = S_IDLE;
      end
      S_D_RESP: begin
        mem_rready  = data_rready;
        data_rvalid = mem_rvalid;
        data_rdata  = mem_rdata;
        if (mem_rvalid && data_rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// Directed bench for mem_bus_arbiter: vector table plus multi-cycle sequences.
module tb_mem_bus_arbiter;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      inst_addr;
  logic             inst_req_valid;
  logic             inst_req_ready;
  logic [31:0]      inst_rdata;
  logic             inst_rvalid;
  logic             inst_rready;
  logic [31:0]      data_addr;
  logic             data_ren;
  logic             data_wen;
  logic [31:0]      data_wdata;
  logic [3:0]       data_wstrb;
  logic             data_req_ready;
  logic [31:0]      data_rdata;
  logic             data_rvalid;
  logic             data_rready;
  logic [31:0]      mem_addr;
  logic             mem_read;
  logic             mem_write;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_req_ready;
  logic [31:0]      mem_rdata;
  logic             mem_rvalid;
  logic             mem_rready;
  logic [CNT_W-1:0] inst_grant_cnt;
  logic [CNT_W-1:0] data_grant_cnt;
  logic [CNT_W-1:0] contend_cnt;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.STARVE_MAX(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
    .data_addr(data_addr), .data_ren(data_ren), .data_wen(data_wen),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_req_ready(data_req_ready),
    .data_rdata(data_rdata), .data_rvalid(data_rvalid), .data_rready(data_rready),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .inst_grant_cnt(inst_grant_cnt), .data_grant_cnt(data_grant_cnt), .contend_cnt(contend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;   logic [31:0] ia;   logic        irr;
    logic        dr;   logic        dw;   logic [31:0] da;
    logic [31:0] dwd;  logic [3:0]  dws;  logic        drr;
    logic        mrdy; logic [31:0] mrd;  logic        mrv;
    logic        e_irdy; logic        e_drdy; logic        e_mr;  logic        e_mw;
    logic [31:0] e_ma;   logic [31:0] e_mwd;  logic [3:0]  e_mws; logic        e_mrr;
    logic        e_irv;  logic [31:0] e_ird;  logic        e_drv; logic [31:0] e_drd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_addr = '0; inst_req_valid = 0; inst_rready = 0;
    data_addr = '0; data_ren = 0; data_wen = 0; data_wdata = '0; data_wstrb = '0; data_rready = 0;
    mem_req_ready = 0; mem_rdata = '0; mem_rvalid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [138:0] act_v, exp_v;
  int idle_both, gd, first_i;

  initial begin
    // fetch 0x100, response two cycles after acceptance
    vecs[0]  = '{0,32'h0,0, 0,0,32'h0,32'h0,4'h0,0, 0,32'h0,0,   0,0,0,0,32'h0,32'h0,4'h0,0,0,32'h0,0,32'h0};
    vecs[1]  = '{1,32'h100,1, 0,0,32'h0,32'h0,4'h0,0, 1,32'h0,0, 0,0,0,0,32'h0,32'h0,4'h0,0,0,32'h0,0,32'h0};
    vecs[2]  = '{1,32'h100,1, 0,0,32'h0,32'h0,4'h0,0, 1,32'h0,0, 1,0,1,0,32'h100,32'h0,4'h0,0,0,32'h0,0,32'h0};
    vecs[3]  = '{0,32'h0,1, 0,0,32'h0,32'h0,4'h0,0, 1,32'h0,0,   0,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,0,32'h0};
    vecs[4]  = '{0,32'h0,1, 0,0,32'h0,32'h0,4'h0,0, 1,32'h13,1,  0,0,0,0,32'h0,32'h0,4'h0,1,1,32'h13,0,32'h0};
    vecs[5]  = '{0,32'h0,0, 0,0,32'h0,32'h0,4'h0,0, 0,32'h0,0,   0,0,0,0,32'h0,32'h0,4'h0,0,0,32'h0,0,32'h0};
    // store with mem_req_ready delayed three cycles
    vecs[6]  = '{0,32'h0,0, 0,1,32'h2000,32'hDEADBEEF,4'hF,0, 0,32'h0,0, 0,0,0,0,32'h0,32'h0,4'h0,0,0,32'h0,0,32'h0};
    vecs[7]  = '{0,32'h0,0, 0,1,32'h2000,32'hDEADBEEF,4'hF,0, 0,32'h0,0, 0,0,0,1,32'h2000,32'hDEADBEEF,4'hF,0,0,32'h0,0,32'h0};
    vecs[8]  = vecs[7];
    vecs[9]  = vecs[7];
    vecs[10] = '{0,32'h0,0, 0,1,32'h2000,32'hDEADBEEF,4'hF,0, 1,32'h0,0, 0,1,0,1,32'h2000,32'hDEADBEEF,4'hF,0,0,32'h0,0,32'h0};
    vecs[11] = vecs[5];
    // ren and wen together behave as a write
    vecs[12] = '{0,32'h0,0, 1,1,32'h3000,32'h12345678,4'h3,0, 1,32'h0,0, 0,0,0,0,32'h0,32'h0,4'h0,0,0,32'h0,0,32'h0};
    vecs[13] = '{0,32'h0,0, 1,1,32'h3000,32'h12345678,4'h3,0, 1,32'h0,0, 0,1,0,1,32'h3000,32'h12345678,4'h3,0,0,32'h0,0,32'h0};
    vecs[14] = '{0,32'h0,0, 0,0,32'h0,32'h0,4'h0,1, 1,32'hBAD,1, 0,0,0,0,32'h0,32'h0,4'h0,0,0,32'h0,0,32'h0};

    do_reset();
    chk("rst_inst_grant", inst_grant_cnt, 0);
    chk("rst_data_grant", data_grant_cnt, 0);
    chk("rst_contend", contend_cnt, 0);

    for (int i = 0; i < 15; i++) begin
      inst_req_valid = vecs[i].iv;  inst_addr = vecs[i].ia;  inst_rready = vecs[i].irr;
      data_ren = vecs[i].dr;  data_wen = vecs[i].dw;  data_addr = vecs[i].da;
      data_wdata = vecs[i].dwd;  data_wstrb = vecs[i].dws;  data_rready = vecs[i].drr;
      mem_req_ready = vecs[i].mrdy;  mem_rdata = vecs[i].mrd;  mem_rvalid = vecs[i].mrv;
      #1;
      act_v = {inst_req_ready, data_req_ready, mem_read, mem_write, mem_addr, mem_wdata,
               mem_wstrb, mem_rready, inst_rvalid, inst_rdata, data_rvalid, data_rdata};
      exp_v = {vecs[i].e_irdy, vecs[i].e_drdy, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_ma,
               vecs[i].e_mwd, vecs[i].e_mws, vecs[i].e_mrr, vecs[i].e_irv, vecs[i].e_ird,
               vecs[i].e_drv, vecs[i].e_drd};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL vec[%0d]: got %h expected %h", i, act_v, exp_v);
      end
      tick();
    end
    chk("tbl_inst_grant", inst_grant_cnt, 1);
    chk("tbl_data_grant", data_grant_cnt, 2);
    chk("tbl_contend", contend_cnt, 0);

    // load response held off by data_rready for five cycles
    idle_inputs();
    data_ren = 1; data_addr = 32'h40; mem_req_ready = 1;
    tick();
    #1;
    chk("bp_mem_read", mem_read, 1);
    chk("bp_data_req_ready", data_req_ready, 1);
    tick();
    data_ren = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; data_rready = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold_mem_rready", mem_rready, 0);
      chk("bp_hold_data_rvalid", data_rvalid, 1);
      tick();
    end
    data_rready = 1;
    #1;
    chk("bp_done_mem_rready", mem_rready, 1);
    chk("bp_done_data_rdata", data_rdata, 32'hCAFEF00D);
    tick();
    #1;
    chk("bp_back_idle", mem_rready, 0);
    idle_inputs();

    // sustained contention with back-to-back loads
    do_reset();
    inst_req_valid = 1; inst_addr = 32'h400; inst_rready = 1;
    data_ren = 1; data_addr = 32'h80; data_rready = 1;
    mem_req_ready = 1; mem_rvalid = 1; mem_rdata = 32'h77;
    idle_both = 0; gd = 0; first_i = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (!(mem_read | mem_write | mem_rready) && inst_req_valid && data_ren) idle_both++;
      if (data_req_ready) gd++;
      if (inst_req_ready && first_i < 0) first_i = c;
      tick();
    end
    idle_inputs();
    #1;
    chk("cont_fetch_cycle", first_i, 10);
    chk("cont_data_grants_obs", gd, 3);
    chk("cont_contend_model", contend_cnt, idle_both);
    chk("cont_contend", contend_cnt, 4);
    chk("cont_inst_grant", inst_grant_cnt, 1);
    chk("cont_data_grant", data_grant_cnt, 3);

    // reset while waiting for a fetch response
    tick();
    inst_req_valid = 1; inst_addr = 32'h200; inst_rready = 1; mem_req_ready = 1;
    tick();
    #1;
    chk("rm_i_req_read", mem_read, 1);
    tick();
    inst_req_valid = 0;
    #1;
    chk("rm_in_resp", mem_rready, 1);
    rst = 1;
    tick();
    rst = 0; mem_rvalid = 1; mem_rdata = 32'hBAADF00D;
    #1;
    chk("rm_mem_rready", mem_rready, 0);
    chk("rm_inst_rvalid", inst_rvalid, 0);
    chk("rm_inst_rdata", inst_rdata, 0);
    chk("rm_inst_grant", inst_grant_cnt, 0);
    chk("rm_data_grant", data_grant_cnt, 0);
    chk("rm_contend", contend_cnt, 0);
    tick();
    #1;
    chk("rm_stay_idle", {mem_read, mem_write, mem_rready, inst_rvalid}, 0);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
